// File: rtl/ascon_round_fsm.sv
// Ascon encryption control FSM: sequences p^a/p^b rounds over an external round
// counter and raises the datapath strobes for init, AD, plaintext blocks and tag.
module ascon_round_fsm #(
    parameter int unsigned NB_BLOCKS = 4
) (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic       data_valid_i,
    input  logic [3:0] cpt_i,
    output logic       en_cpt_o,
    output logic       init_a_o,
    output logic       init_b_o,
    output logic       en_round_o,
    output logic       sel_init_o,
    output logic       en_xor_data_b_o,
    output logic       en_xor_key_b_o,
    output logic       en_xor_key_e_o,
    output logic       en_xor_lsb_e_o,
    output logic       en_cipher_o,
    output logic       en_tag_o,
    output logic       cipher_valid_o,
    output logic       end_o
);

    localparam int unsigned CPT_W = 4;
    localparam int unsigned BLK_W = 4;

    localparam logic [CPT_W-1:0] CPT_ZERO = CPT_W'(0);
    localparam logic [CPT_W-1:0] CPT_MID  = CPT_W'(6);
    localparam logic [CPT_W-1:0] CPT_LAST = CPT_W'(11);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(NB_BLOCKS - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INIT_R  = 3'd1;
    localparam logic [2:0] S_AD_WAIT = 3'd2;
    localparam logic [2:0] S_AD_R    = 3'd3;
    localparam logic [2:0] S_PT_WAIT = 3'd4;
    localparam logic [2:0] S_PT_R    = 3'd5;
    localparam logic [2:0] S_FIN_R   = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    logic [2:0]       state_q, state_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic             cipher_valid_q;
    logic             round_end;
    logic             last_blk;

    // Counter values past 11 close the phase just like 11 does.
    assign round_end      = (cpt_i >= CPT_LAST);
    assign last_blk       = (blk_q == BLK_LAST);
    assign cipher_valid_o = cipher_valid_q;

    // State, block counter and ciphertext-valid registers.
    always_ff @(posedge clock_i) begin
        if (resetb_i) begin
            state_q        <= S_IDLE;
            blk_q          <= '0;
            cipher_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            blk_q          <= blk_d;
            cipher_valid_q <= en_cipher_o;
        end
    end

    // Next state and strobe decode.
    always_comb begin
        state_d         = state_q;
        blk_d           = blk_q;
        en_cpt_o        = 1'b0;
        init_a_o        = 1'b0;
        init_b_o        = 1'b0;
        en_round_o      = 1'b0;
        sel_init_o      = 1'b0;
        en_xor_data_b_o = 1'b0;
        en_xor_key_b_o  = 1'b0;
        en_xor_key_e_o  = 1'b0;
        en_xor_lsb_e_o  = 1'b0;
        en_cipher_o     = 1'b0;
        en_tag_o        = 1'b0;
        end_o           = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    init_a_o = 1'b1;
                    state_d  = S_INIT_R;
                end
            end
            S_INIT_R: begin
                en_round_o = 1'b1;
                en_cpt_o   = 1'b1;
                if (cpt_i == CPT_ZERO) sel_init_o = 1'b1;
                if (round_end) begin
                    en_xor_key_e_o = 1'b1;
                    state_d        = S_AD_WAIT;
                end
            end
            S_AD_WAIT: begin
                init_b_o = 1'b1;
                if (data_valid_i) state_d = S_AD_R;
            end
            S_AD_R: begin
                en_round_o = 1'b1;
                en_cpt_o   = 1'b1;
                if (cpt_i == CPT_MID) en_xor_data_b_o = 1'b1;
                if (round_end) begin
                    en_xor_lsb_e_o = 1'b1;
                    blk_d          = '0;
                    state_d        = S_PT_WAIT;
                end
            end
            S_PT_WAIT: begin
                // The last block runs the 12-round finalisation, so preload 0.
                if (last_blk) init_a_o = 1'b1;
                else          init_b_o = 1'b1;
                if (data_valid_i) state_d = last_blk ? S_FIN_R : S_PT_R;
            end
            S_PT_R: begin
                en_round_o = 1'b1;
                en_cpt_o   = 1'b1;
                if (cpt_i == CPT_MID) begin
                    en_xor_data_b_o = 1'b1;
                    en_cipher_o     = 1'b1;
                end
                if (round_end) begin
                    blk_d   = blk_q + BLK_W'(1);
                    state_d = S_PT_WAIT;
                end
            end
            S_FIN_R: begin
                en_round_o = 1'b1;
                en_cpt_o   = 1'b1;
                if (cpt_i == CPT_ZERO) begin
                    en_xor_data_b_o = 1'b1;
                    en_xor_key_b_o  = 1'b1;
                    en_cipher_o     = 1'b1;
                end
                if (round_end) begin
                    en_xor_key_e_o = 1'b1;
                    en_tag_o       = 1'b1;
                    state_d        = S_DONE;
                end
            end
            S_DONE: begin
                end_o = 1'b1;
                if (!start_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ascon_round_fsm.sv
// Bench for ascon_round_fsm: schedule-based reference model feeding a scoreboard,
// plus directed reset, stall, counter-overrun and single-block checks.
`timescale 1ns/1ps
module tb_ascon_round_fsm;

    localparam int unsigned NB   = 4;
    localparam int unsigned MAXS = 6;
    localparam int K_CV      = 0;
    localparam int K_END_UP  = 1;
    localparam int K_END_DN  = 2;

    typedef struct {
        int          kind;
        int unsigned at;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // NB=4 instance
    logic       start, dv, ovr_en;
    logic [3:0] cpt_q, cpt_i, ovr_val;
    logic en_cpt, init_a, init_b, en_round, sel_init, x_db, x_kb, x_ke, x_le;
    logic en_cipher, en_tag, cv, end_s;
    logic [12:0] outs;

    ascon_round_fsm #(.NB_BLOCKS(NB)) dut (
        .clock_i(clk), .resetb_i(rst), .start_i(start), .data_valid_i(dv), .cpt_i(cpt_i),
        .en_cpt_o(en_cpt), .init_a_o(init_a), .init_b_o(init_b), .en_round_o(en_round),
        .sel_init_o(sel_init), .en_xor_data_b_o(x_db), .en_xor_key_b_o(x_kb),
        .en_xor_key_e_o(x_ke), .en_xor_lsb_e_o(x_le), .en_cipher_o(en_cipher),
        .en_tag_o(en_tag), .cipher_valid_o(cv), .end_o(end_s)
    );

    assign outs  = {en_cpt, init_a, init_b, en_round, sel_init, x_db, x_kb, x_ke, x_le,
                    en_cipher, en_tag, cv, end_s};
    assign cpt_i = ovr_en ? ovr_val : cpt_q;

    // External round counter the FSM steers.
    always_ff @(posedge clk) begin
        if (rst)         cpt_q <= 4'd0;
        else if (init_a) cpt_q <= 4'd0;
        else if (init_b) cpt_q <= 4'd6;
        else if (en_cpt) cpt_q <= cpt_q + 4'd1;
    end

    // NB=1 instance
    logic       start1, dv1;
    logic [3:0] cpt1;
    logic en_cpt1, init_a1, init_b1, en_round1, sel_init1, x_db1, x_kb1, x_ke1, x_le1;
    logic en_cipher1, en_tag1, cv1, end1;

    ascon_round_fsm #(.NB_BLOCKS(1)) dut1 (
        .clock_i(clk), .resetb_i(rst), .start_i(start1), .data_valid_i(dv1), .cpt_i(cpt1),
        .en_cpt_o(en_cpt1), .init_a_o(init_a1), .init_b_o(init_b1), .en_round_o(en_round1),
        .sel_init_o(sel_init1), .en_xor_data_b_o(x_db1), .en_xor_key_b_o(x_kb1),
        .en_xor_key_e_o(x_ke1), .en_xor_lsb_e_o(x_le1), .en_cipher_o(en_cipher1),
        .en_tag_o(en_tag1), .cipher_valid_o(cv1), .end_o(end1)
    );

    always_ff @(posedge clk) begin
        if (rst)          cpt1 <= 4'd0;
        else if (init_a1) cpt1 <= 4'd0;
        else if (init_b1) cpt1 <= 4'd6;
        else if (en_cpt1) cpt1 <= cpt1 + 4'd1;
    end

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    ev_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pop_check(input int kind);
        ev_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: event kind %0d at cycle %0d, none expected", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.at != cyc) begin
                n_fail++;
                $display("FAIL sb_event: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                         kind, cyc, e.kind, e.at);
            end
        end
    endtask

    // Monitor: every ciphertext-valid pulse and end_o edge must match the queue head.
    logic end_prev = 1'b0;
    always @(negedge clk) begin
        if (cv)                 pop_check(K_CV);
        if (end_s && !end_prev) pop_check(K_END_UP);
        if (!end_s && end_prev) pop_check(K_END_DN);
        end_prev = end_s;
    end

    int unsigned stall [NB+1];
    int unsigned pw    [NB];
    bit          noise;
    int unsigned n_sel, n_cip, n_tag, tag_bad, hold_bad;

    // One encryption; caller is #1 after a posedge with the DUT idle.
    // Wait phases last 1+stall cycles, AD/PT rounds 6, init/final 12.
    task automatic run_enc(input int unsigned hold);
        int unsigned t0, p, r, d, len;
        bit w, st;
        t0 = cyc;
        p  = 14 + stall[0] + 6;
        d  = 0;
        for (int b = 0; b < int'(NB); b++) begin
            pw[b] = p;
            r = p + 1 + stall[b+1];
            exp_q.push_back('{K_CV, t0 + r + 1});
            if (b < int'(NB) - 1) p = r + 6;
            else                  d = r + 12;
        end
        exp_q.push_back('{K_END_UP, t0 + d});
        exp_q.push_back('{K_END_DN, t0 + d + hold + 1});
        len = d + hold + 1;
        n_sel = 0; n_cip = 0; n_tag = 0; tag_bad = 0; hold_bad = 0;
        for (int unsigned c = 0; c <= len; c++) begin
            w  = 1'b0;
            st = 1'b0;
            if (c >= 13 && c <= 13 + stall[0]) begin
                w = 1'b1; st = (c < 13 + stall[0]);
            end
            for (int b = 0; b < int'(NB); b++)
                if (c >= pw[b] && c <= pw[b] + stall[b+1]) begin
                    w = 1'b1; st = (c < pw[b] + stall[b+1]);
                end
            dv = w ? !st : 1'($urandom_range(0, 1));
            if (c == 0)      start = 1'b1;
            else if (c >= d) start = (c < d + hold);
            else             start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            if (sel_init) n_sel++;
            if (en_cipher) n_cip++;
            if (en_tag) begin
                n_tag++;
                if (!x_ke) tag_bad++;
            end
            if (st && (!(init_a || init_b) || en_round || en_cipher)) hold_bad++;
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    int unsigned n1_cv, cv1_at, end1_at;

    initial begin
        rst = 1'b1; start = 1'b0; dv = 1'b0; ovr_en = 1'b0; ovr_val = 4'd0;
        start1 = 1'b0; dv1 = 1'b1; noise = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outs", 32'(outs), 0);
        chk("reset_outs_nb1", 32'({en_cpt1, init_a1, init_b1, en_round1, en_cipher1, cv1, end1}), 0);
        @(posedge clk); #1;

        // Nominal run, no stalls, start held 3 cycles into DONE.
        foreach (stall[i]) stall[i] = 0;
        run_enc(3);
        chk("sel_init_cycles", n_sel, 1);
        chk("en_cipher_pulses", n_cip, 4);
        chk("en_tag_pulses", n_tag, 1);
        chk("tag_without_key_e", tag_bad, 0);

        // Five-cycle stall before the second plaintext block.
        stall[2] = 5;
        run_enc(0);
        chk("stall_hold_violations", hold_bad, 0);
        chk("stall_cipher_pulses", n_cip, 4);

        // Reset while AD rounds are at counter value 8.
        start = 1'b1; dv = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(negedge clk);
        chk("midrun_cpt_is_8", 32'(cpt_q), 8);
        chk("midrun_en_round", 32'(en_round), 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; dv = 1'b0;
        @(negedge clk);
        chk("after_midrun_reset_outs", 32'(outs), 0);
        @(posedge clk); #1;
        foreach (stall[i]) stall[i] = 0;
        run_enc(1);
        chk("replay_cipher_pulses", n_cip, 4);

        // Counter value above 11 ends the init phase early.
        start = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            start = 1'b0; dv = 1'b0;
        end
        ovr_en = 1'b1; ovr_val = 4'd13;
        @(negedge clk);
        chk("overrun_key_e", 32'(x_ke), 1);
        chk("overrun_en_round", 32'(en_round), 1);
        @(posedge clk); #1 ovr_en = 1'b0;
        @(negedge clk);
        chk("overrun_ad_wait_init_b", 32'(init_b), 1);
        chk("overrun_ad_wait_no_round", 32'(en_round), 0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;

        // Single-block message on the NB=1 instance.
        n1_cv = 0; cv1_at = 0; end1_at = 0;
        start1 = 1'b1;
        for (int unsigned c = 0; c < 40; c++) begin
            if (c == 1) start1 = 1'b0;
            @(negedge clk);
            if (c == 20) begin
                chk("nb1_pt_wait_init_a", 32'(init_a1), 1);
                chk("nb1_pt_wait_init_b", 32'(init_b1), 0);
            end
            if (cv1) begin n1_cv++; cv1_at = c; end
            if (end1 && end1_at == 0) end1_at = c;
            @(posedge clk); #1;
        end
        chk("nb1_cipher_pulses", n1_cv, 1);
        chk("nb1_cipher_valid_cycle", cv1_at, 22);
        chk("nb1_end_cycle", end1_at, 33);

        // Randomised stalls, ignored start/data_valid noise, random DONE hold.
        noise = 1'b1;
        for (int k = 0; k < 8; k++) begin
            foreach (stall[i]) stall[i] = $urandom_range(0, MAXS);
            run_enc($urandom_range(0, 3));
            chk("rand_cipher_pulses", n_cip, 4);
            chk("rand_stall_hold", hold_bad, 0);
            repeat ($urandom_range(0, 3)) begin
                dv = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
